// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, memory strobe values and FSM states.
// The RMW_RD/MERGE states only exist when LSU_RMW_EN is defined.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [1:0] MEM_IDLE = 2'd0;
    localparam logic [1:0] MEM_ACT  = 2'd1;

`ifdef LSU_RMW_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WAIT   = 3'd2,
        ST_WR     = 3'd3,
        ST_RESP   = 3'd4,
        ST_RMW_RD = 3'd5,
        ST_MERGE  = 3'd6
    } lsu_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_e;
`endif

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        if (size == SZ_H && offset[0])
            bad = 1'b1;
        if (size == SZ_W && offset != 2'b00)
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane extract with sign/zero extension for loads, and lane merge for sub-word stores.
// The merge path is only present when LSU_RMW_EN is defined.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_signed,
`ifdef LSU_RMW_EN
    input  logic [31:0] st_data,
    output logic [31:0] merged_word,
`endif
    output logic [31:0] load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Byte offset 0 lives in the most significant lane.
    always_comb begin
        lane_byte = rd_word[31:24];
        case (offset)
            2'd0: lane_byte = rd_word[31:24];
            2'd1: lane_byte = rd_word[23:16];
            2'd2: lane_byte = rd_word[15:8];
            2'd3: lane_byte = rd_word[7:0];
            default: lane_byte = rd_word[31:24];
        endcase
        lane_half = offset[1] ? rd_word[15:0] : rd_word[31:16];
    end

    always_comb begin
        load_data = rd_word;
        case (size)
            SZ_B: load_data = is_signed ? {{24{lane_byte[7]}}, lane_byte} : {24'd0, lane_byte};
            SZ_H: load_data = is_signed ? {{16{lane_half[15]}}, lane_half} : {16'd0, lane_half};
            default: load_data = rd_word;
        endcase
    end

`ifdef LSU_RMW_EN
    always_comb begin
        merged_word = rd_word;
        case (size)
            SZ_B: begin
                case (offset)
                    2'd0: merged_word[31:24] = st_data[7:0];
                    2'd1: merged_word[23:16] = st_data[7:0];
                    2'd2: merged_word[15:8]  = st_data[7:0];
                    2'd3: merged_word[7:0]   = st_data[7:0];
                    default: merged_word = rd_word;
                endcase
            end
            SZ_H: begin
                if (offset[1])
                    merged_word[15:0] = st_data[15:0];
                else
                    merged_word[31:16] = st_data[15:0];
            end
            default: merged_word = st_data;
        endcase
    end
`endif

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a 256-byte big-endian data memory, one request in flight at a time.
// Define LSU_RMW_EN to support byte/half stores via read-modify-write; otherwise they are errors.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_write,
    output logic [1:0]  mem_read,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_err;
    logic [31:0] load_data;
`ifdef LSU_RMW_EN
    logic [31:0] merged_word;
`endif

    lsu_lane_align u_align (
        .rd_word     (mem_rdata),
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .is_signed   (signed_q),
`ifdef LSU_RMW_EN
        .st_data     (mem_wdata_q),
        .merged_word (merged_word),
`endif
        .load_data   (load_data)
    );

    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'd3)
            req_err = 1'b1;
        if (is_misaligned(req_size, req_addr[1:0]))
            req_err = 1'b1;
        if (req_addr >= 32'(MEM_BYTES))
            req_err = 1'b1;
`ifndef LSU_RMW_EN
        if (req_we && req_size != SZ_W)
            req_err = 1'b1;
`endif
    end

    // Store data parks in mem_wdata_q from accept; RMW merges into it before the write.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        signed_d    = signed_q;
        addr_d      = addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    size_d      = req_size;
                    signed_d    = req_signed;
                    addr_d      = req_addr;
                    mem_wdata_d = req_wdata;
                    rdata_d     = 32'd0;
                    err_d       = req_err;
                    if (req_err)
                        state_d = ST_RESP;
                    else if (!req_we)
                        state_d = ST_RD;
`ifdef LSU_RMW_EN
                    else if (req_size != SZ_W)
                        state_d = ST_RMW_RD;
`endif
                    else
                        state_d = ST_WR;
                end
            end
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: begin
                rdata_d = load_data;
                state_d = ST_RESP;
            end
`ifdef LSU_RMW_EN
            ST_RMW_RD: state_d = ST_MERGE;
            ST_MERGE: begin
                mem_wdata_d = merged_word;
                state_d     = ST_WR;
            end
`endif
            ST_WR:   state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            size_q      <= SZ_B;
            signed_q    <= 1'b0;
            addr_q      <= 32'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Strobes are masked by reset so a reset edge never touches memory.
    always_comb begin
        mem_read  = MEM_IDLE;
        mem_write = MEM_IDLE;
        if (!rst) begin
            if (state_q == ST_RD)
                mem_read = MEM_ACT;
`ifdef LSU_RMW_EN
            if (state_q == ST_RMW_RD)
                mem_read = MEM_ACT;
`endif
            if (state_q == ST_WR)
                mem_write = MEM_ACT;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl with a behavioural 256-byte big-endian memory.
// Sub-word store expectations follow LSU_RMW_EN.
module tb_lsu_mem_ctrl;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rspExp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_write;
    logic [1:0]  mem_read;
    logic [31:0] mem_rdata;

    logic [7:0]  mem [256];
    rspExp_t     expQ[$];
    int          vectorCount;
    int          missCount;
    int          strobeCount;
    int          writeCount;

    lsu_mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: read data appears the cycle after the strobe is sampled.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem_rdata = 32'd0;
        strobeCount = 0;
        writeCount = 0;
    end

    always @(posedge clk) begin
        if (mem_read == 2'd1 || mem_write == 2'd1) strobeCount++;
        if (mem_write == 2'd1) begin
            writeCount++;
            mem[mem_addr[7:0]]        <= mem_wdata[31:24];
            mem[mem_addr[7:0] + 8'd1] <= mem_wdata[23:16];
            mem[mem_addr[7:0] + 8'd2] <= mem_wdata[15:8];
            mem[mem_addr[7:0] + 8'd3] <= mem_wdata[7:0];
        end
        if (mem_read == 2'd1)
            mem_rdata <= {mem[mem_addr[7:0]], mem[mem_addr[7:0] + 8'd1],
                          mem[mem_addr[7:0] + 8'd2], mem[mem_addr[7:0] + 8'd3]};
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request, waits for its response, and checks it against the scoreboard.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expErr,
                                 input int expLat, input int stall);
        rspExp_t e;
        int lat;
        int strobesBefore;
        int expStrobes;
        expStrobes = expErr ? 0 : ((!we || size == 2'd2) ? 1 : 2);
        @(negedge clk);
        checkOutput("reqReady", {31'd0, req_ready}, 32'd1);
        rsp_ready  = (stall == 0);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        e.rdata = expRdata;
        e.err   = expErr;
        expQ.push_back(e);
        strobesBefore = strobeCount;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
        end while (!rsp_valid && lat < 20);
        checkOutput("rspValid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("latency", lat, expLat);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("rspRdata", rsp_rdata, e.rdata);
            checkOutput("rspErr", {31'd0, rsp_err}, {31'd0, e.err});
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                checkOutput("stallValid", {31'd0, rsp_valid}, 32'd1);
                checkOutput("stallRdata", rsp_rdata, e.rdata);
                checkOutput("stallReqReady", {31'd0, req_ready}, 32'd0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rspDone", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reqReadyAfter", {31'd0, req_ready}, 32'd1);
        checkOutput("strobes", strobeCount - strobesBefore, expStrobes);
    endtask

    task automatic checkWordInMem(input string tag, input int base, input logic [31:0] exp);
        checkOutput(tag, {mem[base], mem[base + 1], mem[base + 2], mem[base + 3]}, exp);
    endtask

    initial begin
        int writesBefore;
        vectorCount = 0;
        missCount   = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rstReqReady", {31'd0, req_ready}, 32'd1);
        checkOutput("rstRspValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rstRspErr", {31'd0, rsp_err}, 32'd0);
        checkOutput("rstRspRdata", rsp_rdata, 32'd0);
        checkOutput("rstMemWrite", {30'd0, mem_write}, 32'd0);
        checkOutput("rstMemRead", {30'd0, mem_read}, 32'd0);
        checkOutput("rstMemAddr", mem_addr, 32'd0);
        checkOutput("rstMemWdata", mem_wdata, 32'd0);
        rst = 1'b0;

        applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2, 0);
        checkWordInMem("memAfterStore", 16, 32'hDEADBEEF);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 3, 0);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h12, 32'd0, 32'hFFFFFFBE, 1'b0, 3, 0);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h12, 32'd0, 32'h000000BE, 1'b0, 3, 0);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, 32'h0000BEEF, 1'b0, 3, 0);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h10, 32'd0, 32'hFFFFDEAD, 1'b0, 3, 0);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 32'h000000EF, 1'b0, 3, 0);

`ifdef LSU_RMW_EN
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000055, 32'd0, 1'b0, 4, 0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 32'hDE55BEEF, 1'b0, 3, 0);
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, 32'd0, 1'b0, 4, 0);
        checkWordInMem("memAfterRmw", 16, 32'hDE551234);
`else
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000055, 32'd0, 1'b1, 1, 0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 3, 0);
        checkWordInMem("memNoRmw", 16, 32'hDEADBEEF);
`endif

        applyStimulus(1'b0, 2'd1, 1'b0, 32'h11, 32'd0, 32'd0, 1'b1, 1, 0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h12, 32'd0, 32'd0, 1'b1, 1, 0);
        applyStimulus(1'b0, 2'd3, 1'b0, 32'h10, 32'd0, 32'd0, 1'b1, 1, 0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 32'd0, 1'b1, 1, 0);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h104, 32'h12345678, 32'd0, 1'b1, 1, 0);

        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'd0,
`ifdef LSU_RMW_EN
                      32'hDE551234,
`else
                      32'hDEADBEEF,
`endif
                      1'b0, 3, 5);

        // Reset during the write cycle must suppress the write and the response.
        @(negedge clk);
        writesBefore = writeCount;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h20;
        req_wdata = 32'h11223344;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstWrReqReady", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("rstWrNoRsp", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
        end
        checkOutput("rstWrNoWrite", writeCount - writesBefore, 32'd0);
        checkWordInMem("rstWrMem", 32, 32'h00000000);

        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'd0,
`ifdef LSU_RMW_EN
                      32'hDE551234,
`else
                      32'hDEADBEEF,
`endif
                      1'b0, 3, 0);

        checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
